riscv_alu: RTL and testbench



---
 rtl/riscv_alu.sv | 83 ++++++++
 tb/tb_riscv_alu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu.sv
// riscv_alu: registered RV32 integer ALU, one-cycle latency, full throughput.
// Optional macro ALU_SLT_EN: opcode 011 performs signed set-less-than.
module riscv_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    input  logic             in_valid,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             signFlag,
    output logic             out_valid
);

    logic [WIDTH-1:0]   res_c;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   res_d, res_q;
    logic               zero_d, zero_q;
    logic               sign_d, sign_q;
    logic               valid_d, valid_q;

    assign shamt = B[SHAMT_W-1:0];

    // Combinational operation select; unknown or unused codes yield zero.
    always_comb begin
        res_c = '0;
        case (ALUControl)
            3'b000: res_c = A + B;
            3'b001: res_c = A << shamt;
            3'b010: res_c = A - B;
`ifdef ALU_SLT_EN
            3'b011: res_c = {{(WIDTH-1){1'b0}},
                             ($signed(A) < $signed(B))};
`else
            3'b011: res_c = '0;
`endif
            3'b100: res_c = A ^ B;
            3'b101: res_c = A >> shamt;
            3'b110: res_c = A | B;
            3'b111: res_c = A & B;
            default: res_c = '0;
        endcase
    end

    // Next state: load result and flags on a valid input, otherwise hold.
    always_comb begin
        res_d   = res_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        valid_d = 1'b0;
        if (in_valid) begin
            res_d   = res_c;
            zero_d  = ~|res_c;
            sign_d  = res_c[WIDTH-1];
            valid_d = 1'b1;
        end
    end

    // Output registers with synchronous reset that discards any pending input.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            zero_q  <= 1'b1;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
            valid_q <= valid_d;
        end
    end

    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign signFlag  = sign_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu: directed vector table plus hold, reset and random checks.
// Honors ALU_SLT_EN for the expected result of opcode 011.
module tb_riscv_alu;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUControl;
    logic        in_valid;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        signFlag;
    logic        out_valid;

    int passed;
    int total;

    riscv_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .in_valid   (in_valid),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .signFlag   (signFlag),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        s;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic check_all(input string name, input logic [31:0] r,
                             input logic z, input logic s, input logic v);
        check({name, ".res"},   ALUResult,        r);
        check({name, ".zero"},  {31'b0, Zero},     {31'b0, z});
        check({name, ".sign"},  {31'b0, signFlag}, {31'b0, s});
        check({name, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = a - b;
`ifdef ALU_SLT_EN
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`else
            3'd3: r = 32'd0;
`endif
            3'd4: r = a ^ b;
            3'd5: r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    logic [31:0] exp_r;
    logic        exp_z;
    logic        exp_s;
    logic [31:0] held;

    initial begin
        passed = 0;
        total  = 0;

`ifdef ALU_SLT_EN
        vecs[3]  = '{3'd3, 32'h1, 32'h2, 32'h1, 1'b0, 1'b0};
`else
        vecs[3]  = '{3'd3, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0};
`endif
        vecs[0]  = '{3'd0, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 32'h1, 32'h2, 32'h4, 1'b0, 1'b0};
        vecs[2]  = '{3'd2, 32'h1, 32'h2, 32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[4]  = '{3'd4, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0};
        vecs[5]  = '{3'd5, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0};
        vecs[6]  = '{3'd6, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0};
        vecs[7]  = '{3'd7, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0};
        vecs[8]  = '{3'd2, 32'h12345678, 32'h12345678, 32'h0, 1'b1, 1'b0};
        vecs[9]  = '{3'd5, 32'h80000000, 32'h21, 32'h40000000, 1'b0, 1'b0};
        vecs[10] = '{3'd1, 32'h1, 32'h1F, 32'h80000000, 1'b0, 1'b1};
        vecs[11] = '{3'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0};
        vecs[12] = '{3'd6, 32'hF0F00000, 32'h0000000F, 32'hF0F0000F,
                     1'b0, 1'b1};

        rst = 1'b1;
        A = 32'hDEADBEEF;
        B = 32'h1;
        ALUControl = 3'd0;
        in_valid = 1'b1;
        cycle();
        cycle();
        check_all("reset", 32'h0, 1'b1, 1'b0, 1'b0);

        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            A = vecs[i].a;
            B = vecs[i].b;
            ALUControl = vecs[i].op;
            in_valid = 1'b1;
            cycle();
            check_all($sformatf("vec%0d", i), vecs[i].res, vecs[i].z,
                      vecs[i].s, 1'b1);
        end

        A = 32'h00000010;
        B = 32'h00000005;
        ALUControl = 3'd2;
        in_valid = 1'b1;
        cycle();
        check_all("hold_load", 32'hB, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A = 32'hFFFF0000 + i;
            B = 32'h00001234 * (i + 1);
            ALUControl = 3'(i);
            cycle();
            check_all($sformatf("hold%0d", i), 32'hB, 1'b0, 1'b0, 1'b0);
        end

        A = 32'h7FFFFFFF;
        B = 32'h80000001;
        ALUControl = 3'd0;
        in_valid = 1'b1;
        cycle();
        check_all("pre_rst", 32'h0, 1'b1, 1'b0, 1'b1);
        A = 32'h80000000;
        B = 32'h1;
        ALUControl = 3'd6;
        rst = 1'b1;
        cycle();
        check_all("mid_rst", 32'h0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        exp_r = 32'h0;
        exp_z = 1'b1;
        exp_s = 1'b0;
        for (int i = 0; i < 100; i++) begin
            logic v;
            A = $urandom;
            B = $urandom;
            ALUControl = 3'($urandom_range(0, 7));
            v = ($urandom_range(0, 3) != 0);
            in_valid = v;
            if (v) begin
                exp_r = model(ALUControl, A, B);
                exp_z = (exp_r == 32'h0);
                exp_s = exp_r[31];
            end
            held = exp_r;
            cycle();
            check_all($sformatf("rand%0d", i), held, exp_z, exp_s, v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
